// File: rtl/regs_pkg.sv
// Shared constants for the general-purpose register file.
// Address width and register count are fixed; only the data width is a parameter.
package regs_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regs.sv
// 32-entry register file: one synchronous write port, two combinational read ports.
// Register 0 is hardwired to zero. Reads show stored state only; there is no bypass.
module regs
    import regs_pkg::*;
#(
    parameter int n = 8
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  w,
    input  logic [n-1:0]          w_data,
    input  logic [REG_ADDR_W-1:0] Rd,
    input  logic [REG_ADDR_W-1:0] Rs,
    output logic [n-1:0]          Rd_data,
    output logic [n-1:0]          Rs_data
);

    logic [n-1:0] gpr [NUM_REGS];

    // Reset wins over a coincident write; writes aimed at register 0 are dropped.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (w && (Rd != ZERO_REG)) begin
            gpr[Rd] <= w_data;
        end
    end

    assign Rd_data = gpr[Rd];
    assign Rs_data = gpr[Rs];

    a_zero_reg : assert property (@(posedge clk) disable iff (n_reset) gpr[ZERO_REG] == '0);

    // A register may only change when it is the target of an enabled write.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_hold
        a_hold : assert property (@(posedge clk)
            (!n_reset && (!w || (Rd != REG_ADDR_W'(g)))) |=> $stable(gpr[g]));
    end

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: directed vector table, hand-written corner sequences,
// and randomized traffic compared against an array-based reference model.
module tb_regs;

    localparam int N = 8;

    typedef struct {
        logic         rst;
        logic         w;
        logic [4:0]   rd;
        logic [4:0]   rs;
        logic [N-1:0] d;
        logic [N-1:0] exp_rd;
        logic [N-1:0] exp_rs;
    } vec_t;

    logic         clk     = 1'b0;
    logic         n_reset = 1'b1;
    logic         w       = 1'b0;
    logic [N-1:0] w_data  = '0;
    logic [4:0]   Rd      = '0;
    logic [4:0]   Rs      = '0;
    logic [N-1:0] Rd_data;
    logic [N-1:0] Rs_data;

    logic [N-1:0] model [32];
    vec_t         vecs [12];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regs #(.n(N)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .w       (w),
        .w_data  (w_data),
        .Rd      (Rd),
        .Rs      (Rs),
        .Rd_data (Rd_data),
        .Rs_data (Rs_data)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic [N-1:0] d);
        @(negedge clk);
        n_reset = rst;
        w       = we;
        Rd      = rd;
        Rs      = rs;
        w_data  = d;
    endtask

    // Take one rising edge and advance the reference model by the same rules.
    task automatic clockEdge();
        @(posedge clk);
        if (n_reset) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (w && Rd != 5'd0) begin
            model[Rd] = w_data;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;

        vecs[0]  = '{1'b1, 1'b0, 5'd0,  5'd0,  8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 5'd7,  5'd7,  8'hFF, 8'hFF, 8'hFF};
        vecs[2]  = '{1'b1, 1'b1, 5'd7,  5'd7,  8'hFF, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 5'd0,  5'd0,  8'h12, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 5'd5,  5'd0,  8'hA5, 8'hA5, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 5'd5,  5'd5,  8'h3C, 8'hA5, 8'hA5};
        vecs[6]  = '{1'b0, 1'b1, 5'd1,  5'd5,  8'h11, 8'h11, 8'hA5};
        vecs[7]  = '{1'b0, 1'b1, 5'd2,  5'd1,  8'h22, 8'h22, 8'h11};
        vecs[8]  = '{1'b0, 1'b1, 5'd31, 5'd2,  8'hF0, 8'hF0, 8'h22};
        vecs[9]  = '{1'b0, 1'b0, 5'd31, 5'd31, 8'h00, 8'hF0, 8'hF0};
        vecs[10] = '{1'b1, 1'b0, 5'd31, 5'd5,  8'h00, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 5'd5,  5'd1,  8'h77, 8'h00, 8'h00};

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].w, vecs[v].rd, vecs[v].rs, vecs[v].d);
            clockEdge();
            checkOutput($sformatf("vec%0d Rd_data", v), 32'(Rd_data), 32'(vecs[v].exp_rd));
            checkOutput($sformatf("vec%0d Rs_data", v), 32'(Rs_data), 32'(vecs[v].exp_rs));
        end
        checkOutput("vec gpr[0] after R0 write", 32'(dut.gpr[0]), 32'h0);

        // Reset clears the whole file, including everything written above.
        applyStimulus(1'b0, 1'b1, 5'd12, 5'd0, 8'h9E);
        clockEdge();
        applyStimulus(1'b1, 1'b1, 5'd13, 5'd12, 8'h44);
        clockEdge();
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("reset gpr[%0d]", i), 32'(dut.gpr[i]), 32'h0);
        end
        checkOutput("reset Rd_data", 32'(Rd_data), 32'h0);
        checkOutput("reset Rs_data", 32'(Rs_data), 32'h0);

        // Write sweep over registers 3..31.
        for (int i = 3; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(i), 5'(i - 1), 8'(i));
            clockEdge();
            checkOutput($sformatf("sweep Rd_data r%0d", i), 32'(Rd_data), i);
            if (i != 3) checkOutput($sformatf("sweep Rs_data r%0d", i - 1), 32'(Rs_data), i - 1);
            checkOutput($sformatf("sweep gpr[%0d]", i), 32'(dut.gpr[i]), i);
        end

        // No write-to-read bypass: the old value is visible until the edge.
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 8'h00);
        clockEdge();
        applyStimulus(1'b0, 1'b1, 5'd9, 5'd9, 8'h55);
        #1;
        checkOutput("bypass Rs_data before edge", 32'(Rs_data), 32'h0);
        checkOutput("bypass Rd_data before edge", 32'(Rd_data), 32'h0);
        clockEdge();
        checkOutput("bypass Rs_data after edge", 32'(Rs_data), 32'h55);

        // Randomized traffic against the reference model, checked before and after each edge.
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 8'h00);
        clockEdge();
        for (int t = 0; t < 400; t++) begin
            applyStimulus(($urandom_range(0, 24) == 0), 1'($urandom), 5'($urandom),
                          5'($urandom), 8'($urandom));
            #1;
            checkOutput($sformatf("rand%0d pre Rd_data", t), 32'(Rd_data), 32'(model[Rd]));
            checkOutput($sformatf("rand%0d pre Rs_data", t), 32'(Rs_data), 32'(model[Rs]));
            clockEdge();
            checkOutput($sformatf("rand%0d post Rd_data", t), 32'(Rd_data), 32'(model[Rd]));
            checkOutput($sformatf("rand%0d post Rs_data", t), 32'(Rs_data), 32'(model[Rs]));
        end
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("final gpr[%0d]", i), 32'(dut.gpr[i]), 32'(model[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regs.md
REGS -- requirements
Module: regs

Interface
REQ-001 Parameter: n, default 8, data word width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 n_reset  input  1  reset, synchronous, active-high: port name kept as n_reset per codebase; asserted when 1.
REQ-004 w  input  1  write enable; 1 = write w_data into register Rd at next rising clk edge.
REQ-005 w_data  input  n  write data.
REQ-006 Rd  input  5  destination register address; write target and Rd_data read port.
REQ-007 Rs  input  5  source register address for Rs_data read port.
REQ-008 Rd_data  output  n  contents of register Rd.
REQ-009 Rs_data  output  n  contents of register Rs.

Function
REQ-010 Storage SHALL be 32 registers of n bits, held in an internal array named gpr indexed 0..31, visible hierarchically to benches.
REQ-011 Both read ports SHALL be combinational (zero latency) from the stored array: Rd_data = gpr[Rd], Rs_data = gpr[Rs].
REQ-012 On rising clk with n_reset=0 and w=1 and Rd!=0, gpr[Rd] SHALL take w_data; new value is visible on read ports immediately after that edge.
REQ-013 With w=0, no register SHALL change.
REQ-014 Register 0 SHALL be hardwired to zero: writes to Rd=0 are ignored, gpr[0] stays 0, reads of address 0 return 0 on both ports.
REQ-015 Registers 1 and 2 are software-reserved only; hardware SHALL treat them like 3..31 (writable).
REQ-016 No write-to-read bypass: during the cycle a write is pending, read ports SHALL show the old stored value.
REQ-017 Rd and Rs equal: both ports SHALL return the same value.
REQ-018 Read ports SHALL be purely a function of address and stored state, independent of w and w_data.
REQ-019 All addresses 0..31 are valid; no out-of-range case exists.

Reset
REQ-020 On rising clk with n_reset=1, all 32 registers SHALL become 0 regardless of w, Rd, w_data.
REQ-021 Reset SHALL take priority over a simultaneous write.
REQ-022 After reset, Rd_data and Rs_data SHALL read 0 for any address.
REQ-023 Reset asserted mid-sequence SHALL discard all prior writes; no partial state retained.

Structure
REQ-024 Shared package SHALL hold constants NUM_REGS=32, REG_ADDR_W=5, and ZERO_REG=0.
REQ-025 Single module, no sub-modules; one clocked process for reset/write, combinational read assigns.
REQ-026 Module SHALL include embedded assertions: gpr[0]==0 at all times; no register changes when w=0 and n_reset=0.

Verification
REQ-027 Reset: pulse n_reset=1 for one clk edge -> gpr[0..31] all 0, Rd_data=Rs_data=0.
REQ-028 Write sweep: for i=3..31, w=1, Rd=i, Rs=i-1, w_data=i, one clock -> gpr[i]=i, Rd_data=i, Rs_data=i-1 (Rs_data ignored when Rs=2).
REQ-029 R0 hardwire: after reset, w=1, Rd=0, Rs=0, w_data=12, one clock -> Rd_data=Rs_data=0, gpr[0]=0.
REQ-030 Write disable: write 8'hA5 to R5, then w=0, w_data=8'h3C, Rd=5, clock -> Rd_data stays 8'hA5.
REQ-031 Reset priority: n_reset=1 and w=1, Rd=7, w_data=8'hFF same edge -> gpr[7]=0.
REQ-032 No bypass: w=1, Rd=9, Rs=9, w_data=8'h55 before edge -> Rs_data=0 until edge, 8'h55 after.
